carry_flag_unit: RTL and testbench

//  Parametrised successor to the ALU carry-in selector. Generates alu_cin from the sci mode.

---
 rtl/cpu_alu_pkg.sv | 35 +++
 rtl/cin_mux.sv | 20 ++
 rtl/carry_flag_unit.sv | 126 ++++++++++++
 tb/tb_carry_flag_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_alu_pkg.sv
// Shared definitions for the ALU carry/flag logic: carry-in mode encodings,
// multi-word sequencer states and flag-vector bit positions.
package cpu_alu_pkg;

    localparam logic [1:0] SCI_ZERO  = 2'b00;
    localparam logic [1:0] SCI_ONE   = 2'b01;
    localparam logic [1:0] SCI_FLAG  = 2'b10;
    localparam logic [1:0] SCI_CHAIN = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHAIN = 2'd1,
        ST_DONE  = 2'd2
    } mw_state_t;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_S = 3;
    localparam int FLAG_W = 4;

    // Carry-in outside a chained sequence; SCI_CHAIN has no carry to chain
    // from, so it degenerates to zero.
    function automatic logic sci_base_cin(input logic [1:0] sci, input logic flag_c);
        logic cin;
        case (sci)
            SCI_ZERO: cin = 1'b0;
            SCI_ONE:  cin = 1'b1;
            SCI_FLAG: cin = flag_c;
            default:  cin = 1'b0;
        endcase
        return cin;
    endfunction

endpackage

// File: rtl/cin_mux.sv
// ALU carry-in selector: legacy sci decode, overridden by the chained carry
// while a multi-word operation is running.
module cin_mux
    import cpu_alu_pkg::*;
(
    input  logic [1:0] sci,
    input  logic       flag_c,
    input  logic       chain_c,
    input  logic       chain_active,
    output logic       alu_cin
);

    always_comb begin
        alu_cin = sci_base_cin(sci, flag_c);
        if (chain_active) begin
            alu_cin = chain_c;
        end
    end

endmodule

// File: rtl/carry_flag_unit.sv
// Carry-in generation, C/Z/V/S flag register and multi-word operation
// sequencer sitting between the microcode sequencer and the ALU datapath.
module carry_flag_unit
    import cpu_alu_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int MAX_WORDS = 4,
    parameter int CNT_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       sci,
    input  logic             flag_en,
    input  logic             alu_cout,
    input  logic             alu_ovf,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             mw_start,
    input  logic [CNT_W-1:0] mw_words,
    input  logic             beat_valid,
    output logic             beat_ready,
    output logic             alu_cin,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_s,
    output logic             mw_busy,
    output logic             mw_done
);

    localparam logic [CNT_W-1:0] MAX_WORDS_C = CNT_W'(MAX_WORDS);
    localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(1);

    mw_state_t         state_reg;
    logic [FLAG_W-1:0] flags_reg;
    logic              chain_c_reg;
    logic              z_acc_reg;
    logic [CNT_W-1:0]  words_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              mw_done_reg;

    logic              in_chain;
    logic              result_zero;
    logic              beat_accept;
    logic              last_beat;
    logic [CNT_W-1:0]  words_clamped;

    always_comb begin
        in_chain      = (state_reg == ST_CHAIN);
        result_zero   = (alu_result == '0);
        beat_accept   = in_chain && beat_valid;
        last_beat     = beat_accept && (cnt_reg == (words_reg - ONE_C));
        words_clamped = (mw_words > MAX_WORDS_C) ? MAX_WORDS_C : mw_words;
    end

    // In IDLE the mux output is exactly the starting carry of a new
    // sequence, computed from the flag_c value before any same-cycle load.
    cin_mux u_cin_mux (
        .sci          (sci),
        .flag_c       (flags_reg[FLAG_C]),
        .chain_c      (chain_c_reg),
        .chain_active (in_chain),
        .alu_cin      (alu_cin)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            flags_reg   <= '0;
            chain_c_reg <= 1'b0;
            z_acc_reg   <= 1'b1;
            words_reg   <= '0;
            cnt_reg     <= '0;
            mw_done_reg <= 1'b0;
        end else begin
            mw_done_reg <= last_beat;
            case (state_reg)
                ST_IDLE: begin
                    if (flag_en) begin
                        flags_reg[FLAG_C] <= alu_cout;
                        flags_reg[FLAG_Z] <= result_zero;
                        flags_reg[FLAG_V] <= alu_ovf;
                        flags_reg[FLAG_S] <= alu_result[WIDTH-1];
                    end
                    if (mw_start && (mw_words != '0)) begin
                        state_reg   <= ST_CHAIN;
                        words_reg   <= words_clamped;
                        cnt_reg     <= '0;
                        z_acc_reg   <= 1'b1;
                        chain_c_reg <= alu_cin;
                    end
                end
                ST_CHAIN: begin
                    if (beat_accept) begin
                        chain_c_reg <= alu_cout;
                        z_acc_reg   <= z_acc_reg & result_zero;
                        cnt_reg     <= cnt_reg + ONE_C;
                        if (last_beat) begin
                            flags_reg[FLAG_C] <= alu_cout;
                            flags_reg[FLAG_Z] <= z_acc_reg & result_zero;
                            flags_reg[FLAG_V] <= alu_ovf;
                            flags_reg[FLAG_S] <= alu_result[WIDTH-1];
                            state_reg         <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        beat_ready = in_chain;
        mw_busy    = in_chain;
        mw_done    = mw_done_reg;
        flag_c     = flags_reg[FLAG_C];
        flag_z     = flags_reg[FLAG_Z];
        flag_v     = flags_reg[FLAG_V];
        flag_s     = flags_reg[FLAG_S];
    end

endmodule

// File: tb/tb_carry_flag_unit.sv
// Directed self-checking bench for carry_flag_unit (WIDTH=16, MAX_WORDS=4).
module tb_carry_flag_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  sci = 2'b00;
    logic        flag_en = 1'b0;
    logic        alu_cout = 1'b0;
    logic        alu_ovf = 1'b0;
    logic [15:0] alu_result = 16'h0000;
    logic        mw_start = 1'b0;
    logic [2:0]  mw_words = 3'd0;
    logic        beat_valid = 1'b0;
    logic        beat_ready, alu_cin, flag_c, flag_z, flag_v, flag_s, mw_busy, mw_done;

    int total = 0;
    int bad = 0;

    carry_flag_unit #(.WIDTH(16), .MAX_WORDS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .sci        (sci),
        .flag_en    (flag_en),
        .alu_cout   (alu_cout),
        .alu_ovf    (alu_ovf),
        .alu_result (alu_result),
        .mw_start   (mw_start),
        .mw_words   (mw_words),
        .beat_valid (beat_valid),
        .beat_ready (beat_ready),
        .alu_cin    (alu_cin),
        .flag_c     (flag_c),
        .flag_z     (flag_z),
        .flag_v     (flag_v),
        .flag_s     (flag_s),
        .mw_busy    (mw_busy),
        .mw_done    (mw_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        total++; if ({flag_s, flag_v, flag_z, flag_c} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {flag_s, flag_v, flag_z, flag_c}); end
        total++; if (mw_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", mw_busy); end
        total++; if (beat_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", beat_ready); end
        total++; if (mw_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", mw_done); end
        reset = 1'b1;
        tick();
        $display("reset released");
    endtask

    task automatic test_cin_modes();
        logic [3:0] exp_cin;
        exp_cin = 4'b0110;
        flag_en = 1'b1; alu_cout = 1'b1; alu_result = 16'h0001;
        tick();
        flag_en = 1'b0; alu_cout = 1'b0; alu_result = 16'h0000;
        total++; if (flag_c !== 1'b1) begin bad++; $display("FAIL cin_setup_flag_c got=%b exp=1", flag_c); end
        for (int i = 0; i < 4; i++) begin
            sci = 2'(i);
            #1;
            $display("sci=%0d alu_cin=%b", i, alu_cin);
            total++; if (alu_cin !== exp_cin[i]) begin bad++; $display("FAIL cin_sci%0d got=%b exp=%b", i, alu_cin, exp_cin[i]); end
        end
        sci = 2'b00;
    endtask

    task automatic test_flag_load();
        flag_en = 1'b1; alu_result = 16'h8000; alu_cout = 1'b1; alu_ovf = 1'b1;
        tick();
        flag_en = 1'b0; alu_result = 16'h0000; alu_cout = 1'b0; alu_ovf = 1'b0;
        $display("flag load C=%b Z=%b V=%b S=%b", flag_c, flag_z, flag_v, flag_s);
        total++; if ({flag_s, flag_v, flag_z, flag_c} !== 4'b1101) begin bad++; $display("FAIL flag_load got=%b exp=1101", {flag_s, flag_v, flag_z, flag_c}); end
        tick();
        total++; if ({flag_s, flag_v, flag_z, flag_c} !== 4'b1101) begin bad++; $display("FAIL flag_hold got=%b exp=1101", {flag_s, flag_v, flag_z, flag_c}); end
    endtask

    task automatic test_multiword();
        logic [2:0]  couts;
        logic [2:0]  exp_cin;
        logic [15:0] res [3];
        couts = 3'b101; exp_cin = 3'b011;
        res[0] = 16'h0000; res[1] = 16'h0000; res[2] = 16'h0005;
        sci = 2'b01; mw_words = 3'd3; mw_start = 1'b1;
        tick();
        mw_start = 1'b0;
        total++; if ({mw_busy, beat_ready} !== 2'b11) begin bad++; $display("FAIL mw3_enter got=%b exp=11", {mw_busy, beat_ready}); end
        for (int b = 0; b < 3; b++) begin
            beat_valid = 1'b1; alu_cout = couts[b]; alu_result = res[b];
            #1;
            $display("beat %0d alu_cin=%b", b, alu_cin);
            total++; if (alu_cin !== exp_cin[b]) begin bad++; $display("FAIL mw3_cin_beat%0d got=%b exp=%b", b, alu_cin, exp_cin[b]); end
            total++; if (mw_done !== 1'b0) begin bad++; $display("FAIL mw3_early_done%0d got=%b exp=0", b, mw_done); end
            tick();
        end
        beat_valid = 1'b0; alu_cout = 1'b0; alu_result = 16'h0000;
        total++; if (mw_done !== 1'b1) begin bad++; $display("FAIL mw3_done got=%b exp=1", mw_done); end
        total++; if ({flag_z, flag_c} !== 2'b01) begin bad++; $display("FAIL mw3_flags_zc got=%b exp=01", {flag_z, flag_c}); end
        total++; if (beat_ready !== 1'b0) begin bad++; $display("FAIL mw3_ready_in_done got=%b exp=0", beat_ready); end
        tick();
        total++; if (mw_done !== 1'b0) begin bad++; $display("FAIL mw3_done_pulse got=%b exp=0", mw_done); end
        sci = 2'b00;
    endtask

    task automatic test_stall();
        mw_words = 3'd2; mw_start = 1'b1; alu_result = 16'h0000; alu_cout = 1'b0; alu_ovf = 1'b0;
        tick();
        mw_start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            beat_valid = 1'b0;
            for (int g = 0; g < 3; g++) begin
                tick();
                total++; if ({beat_ready, mw_done} !== 2'b10) begin bad++; $display("FAIL stall_b%0d_g%0d got=%b exp=10", b, g, {beat_ready, mw_done}); end
            end
            beat_valid = 1'b1;
            tick();
            $display("stall beat %0d accepted", b);
        end
        beat_valid = 1'b0;
        total++; if (mw_done !== 1'b1) begin bad++; $display("FAIL stall_done got=%b exp=1", mw_done); end
        total++; if ({flag_s, flag_v, flag_z, flag_c} !== 4'b0010) begin bad++; $display("FAIL stall_flags got=%b exp=0010", {flag_s, flag_v, flag_z, flag_c}); end
        tick();
    endtask

    task automatic test_reset_abort();
        mw_words = 3'd3; mw_start = 1'b1;
        tick();
        mw_start = 1'b0;
        beat_valid = 1'b1; alu_result = 16'h0007; alu_cout = 1'b1;
        tick();
        beat_valid = 1'b0; alu_cout = 1'b0; alu_result = 16'h0000;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        total++; if ({flag_s, flag_v, flag_z, flag_c} !== 4'b0000) begin bad++; $display("FAIL abort_flags got=%b exp=0000", {flag_s, flag_v, flag_z, flag_c}); end
        total++; if (mw_busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", mw_busy); end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (mw_done !== 1'b0) begin bad++; $display("FAIL abort_no_done%0d got=%b exp=0", i, mw_done); end
        end
        mw_words = 3'd2; mw_start = 1'b1;
        tick();
        mw_start = 1'b0;
        total++; if (mw_busy !== 1'b1) begin bad++; $display("FAIL abort_restart_busy got=%b exp=1", mw_busy); end
        beat_valid = 1'b1; alu_result = 16'h0000;
        tick();
        alu_result = 16'h8000; alu_ovf = 1'b1;
        tick();
        beat_valid = 1'b0; alu_result = 16'h0000; alu_ovf = 1'b0;
        $display("restart done=%b flags=%b", mw_done, {flag_s, flag_v, flag_z, flag_c});
        total++; if (mw_done !== 1'b1) begin bad++; $display("FAIL abort_restart_done got=%b exp=1", mw_done); end
        total++; if ({flag_s, flag_v, flag_z, flag_c} !== 4'b1100) begin bad++; $display("FAIL abort_restart_flags got=%b exp=1100", {flag_s, flag_v, flag_z, flag_c}); end
        tick();
    endtask

    task automatic test_bounds();
        mw_words = 3'd0; mw_start = 1'b1;
        tick();
        mw_start = 1'b0;
        total++; if (mw_busy !== 1'b0) begin bad++; $display("FAIL zero_words_busy got=%b exp=0", mw_busy); end
        mw_words = 3'd7; mw_start = 1'b1;
        tick();
        mw_start = 1'b0;
        total++; if (mw_busy !== 1'b1) begin bad++; $display("FAIL clamp_enter got=%b exp=1", mw_busy); end
        for (int b = 0; b < 4; b++) begin
            if (b == 1) begin
                flag_en = 1'b1; mw_start = 1'b1; mw_words = 3'd1;
                alu_cout = 1'b1; alu_ovf = 1'b1; alu_result = 16'h8000;
                tick();
                flag_en = 1'b0; mw_start = 1'b0; alu_ovf = 1'b0;
                total++; if ({mw_busy, flag_c} !== 2'b10) begin bad++; $display("FAIL chain_ignores_ctrl got=%b exp=10", {mw_busy, flag_c}); end
            end
            beat_valid = 1'b1; alu_cout = 1'b0; alu_result = 16'h0001;
            tick();
            beat_valid = 1'b0;
            $display("clamp beat %0d done=%b", b, mw_done);
            if (b < 3) begin
                total++; if ({mw_busy, mw_done} !== 2'b10) begin bad++; $display("FAIL clamp_beat%0d got=%b exp=10", b, {mw_busy, mw_done}); end
            end
        end
        total++; if (mw_done !== 1'b1) begin bad++; $display("FAIL clamp_done got=%b exp=1", mw_done); end
        mw_start = 1'b1; mw_words = 3'd2;
        tick();
        mw_start = 1'b0;
        total++; if ({mw_busy, mw_done} !== 2'b00) begin bad++; $display("FAIL done_ignores_start got=%b exp=00", {mw_busy, mw_done}); end
        mw_words = 3'd1; mw_start = 1'b1; beat_valid = 1'b1; alu_cout = 1'b1; alu_result = 16'h0000;
        tick();
        mw_start = 1'b0;
        total++; if (mw_done !== 1'b0) begin bad++; $display("FAIL single_early got=%b exp=0", mw_done); end
        tick();
        beat_valid = 1'b0;
        total++; if ({mw_done, flag_z, flag_c} !== 3'b111) begin bad++; $display("FAIL single_done got=%b exp=111", {mw_done, flag_z, flag_c}); end
        tick();
    endtask

    initial begin
        test_reset();
        test_cin_modes();
        test_flag_load();
        test_multiword();
        test_stall();
        test_reset_abort();
        test_bounds();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
